pipe_field_controller: RTL and testbench



---
 rtl/pipe_field_controller.sv | 147 ++++++++++++++
 tb/tb_pipe_field_controller.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_field_controller.sv
// Obstacle pipe field: spawns, scrolls and respawns NUM_PIPES pipes and scores bird passes.
// Optional build macro PIPE_SPEEDUP_EN raises the scroll step with the score.
module pipe_field_controller #(
    parameter int NUM_PIPES     = 3,
    parameter int COORD_W       = 17,
    parameter int SCREEN_WIDTH  = 640,
    parameter int PIPE_WIDTH    = 52,
    parameter int PIPE_DISTANCE = 275,
    parameter int TIMER_DIVIDER = 200000,
    parameter int Y_MIN         = 40,
    parameter int RAND_LSB      = 4,
    parameter int BIRD_X        = 160,
    parameter int SPEEDUP_EVERY = 10,
    parameter int MAX_STEP      = 4
) (
    input  logic                          iClock,
    input  logic                          iReset,
    input  logic [1:0]                    iState,
    input  logic [31:0]                   iRandomNumber,
    output logic [NUM_PIPES*COORD_W-1:0]  oPipeX,
    output logic [NUM_PIPES*COORD_W-1:0]  oPipeY,
    output logic                          oTick,
    output logic                          oScorePulse,
    output logic [15:0]                   oScore
);
    localparam int TW = (TIMER_DIVIDER > 1) ? $clog2(TIMER_DIVIDER) : 1;
    localparam logic signed [COORD_W-1:0] INVALID_Y = '1;
    localparam logic signed [COORD_W-1:0] PW_S      = COORD_W'(PIPE_WIDTH);
    localparam logic signed [COORD_W-1:0] NEG_PW_S  = COORD_W'(-PIPE_WIDTH);
    localparam logic signed [COORD_W-1:0] PD_S      = COORD_W'(PIPE_DISTANCE);
    localparam logic signed [COORD_W-1:0] BIRD_S    = COORD_W'(BIRD_X);

    logic signed [COORD_W-1:0] x_q [NUM_PIPES];
    logic signed [COORD_W-1:0] x_d [NUM_PIPES];
    logic signed [COORD_W-1:0] y_q [NUM_PIPES];
    logic signed [COORD_W-1:0] y_d [NUM_PIPES];
    logic signed [COORD_W-1:0] x_tick [NUM_PIPES];
    logic signed [COORD_W-1:0] x_resp [NUM_PIPES];
    logic [NUM_PIPES-1:0]      pass;
    logic signed [COORD_W-1:0] rand_q;
    logic signed [COORD_W-1:0] step;
    logic [TW-1:0]             timer_q, timer_d;
    logic [15:0]               score_q, score_d;
    logic                      run, tick, fill_found, resp_found;
    logic                      unused_rand_bits;

    assign unused_rand_bits = ^iRandomNumber;
    assign run  = (iState == 2'd1) && !iReset;
    assign tick = run && (timer_q == TW'(TIMER_DIVIDER - 1));

`ifdef PIPE_SPEEDUP_EN
    logic [7:0] pts_q, pts_d, level_q, level_d;

    // level saturates at MAX_STEP-1 so step never exceeds MAX_STEP
    assign step = {{(COORD_W-8){1'b0}}, level_q} + COORD_W'(1);

    always_comb begin
        pts_d   = pts_q;
        level_d = level_q;
        if (score_d != score_q) begin
            if (pts_q == 8'(SPEEDUP_EVERY - 1)) begin
                pts_d = '0;
                if (level_q < 8'(MAX_STEP - 1))
                    level_d = level_q + 8'd1;
            end else begin
                pts_d = pts_q + 8'd1;
            end
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset || iState == 2'd0) begin
            pts_q   <= '0;
            level_q <= '0;
        end else begin
            pts_q   <= pts_d;
            level_q <= level_d;
        end
    end
`else
    localparam int unused_speed_cfg = SPEEDUP_EVERY + MAX_STEP;
    assign step = COORD_W'(1);
`endif

    // x_resp uses the predecessor's post-tick X so spacing stays exact
    for (genvar gi = 0; gi < NUM_PIPES; gi++) begin : g_pipe
        assign x_tick[gi] = tick ? (x_q[gi] - step) : x_q[gi];
        assign x_resp[gi] = x_tick[(gi + NUM_PIPES - 1) % NUM_PIPES] + PD_S;
        assign pass[gi]   = tick && (y_q[gi] != INVALID_Y)
                            && (x_q[gi] + PW_S >= BIRD_S)
                            && (x_tick[gi] + PW_S < BIRD_S);
        assign oPipeX[gi*COORD_W +: COORD_W] = x_q[gi];
        assign oPipeY[gi*COORD_W +: COORD_W] = y_q[gi];
    end

    always_comb begin
        timer_d    = timer_q;
        score_d    = score_q;
        fill_found = 1'b0;
        resp_found = 1'b0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            x_d[i] = x_q[i];
            y_d[i] = y_q[i];
        end
        if (run) begin
            timer_d = tick ? '0 : timer_q + TW'(1);
            for (int i = 0; i < NUM_PIPES; i++)
                x_d[i] = x_tick[i];
            for (int i = 0; i < NUM_PIPES; i++) begin
                if (!fill_found && y_q[i] == INVALID_Y) begin
                    fill_found = 1'b1;
                    y_d[i]     = rand_q;
                end
            end
            for (int i = 0; i < NUM_PIPES; i++) begin
                if (!fill_found && !resp_found && x_q[i] < NEG_PW_S) begin
                    resp_found = 1'b1;
                    x_d[i]     = x_resp[i];
                    y_d[i]     = rand_q;
                end
            end
            if (|pass && score_q != 16'hFFFF)
                score_d = score_q + 16'd1;
        end
    end

    always_ff @(posedge iClock) begin
        rand_q <= COORD_W'(Y_MIN) + {{(COORD_W-8){1'b0}}, iRandomNumber[RAND_LSB +: 8]};
        if (iReset || iState == 2'd0) begin
            for (int i = 0; i < NUM_PIPES; i++) begin
                x_q[i] <= COORD_W'(SCREEN_WIDTH + i * PIPE_DISTANCE);
                y_q[i] <= INVALID_Y;
            end
            timer_q <= '0;
            score_q <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            timer_q <= timer_d;
            score_q <= score_d;
        end
    end

    assign oTick       = tick;
    assign oScorePulse = |pass;
    assign oScore      = score_q;
endmodule

// File: tb/tb_pipe_field_controller.sv
// Directed bench for pipe_field_controller with a 4-cycle scroll tick.
module tb_pipe_field_controller;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  state;
    logic [31:0] rnd;
    logic [50:0] pipe_x, pipe_y;
    logic        tick_o, pulse_o;
    logic [15:0] score_o;
    logic signed [16:0] px [3];
    logic signed [16:0] py [3];
    int n_checks = 0;
    int n_fail   = 0;

    pipe_field_controller #(.TIMER_DIVIDER(4)) dut (
        .iClock(clk), .iReset(rst), .iState(state), .iRandomNumber(rnd),
        .oPipeX(pipe_x), .oPipeY(pipe_y), .oTick(tick_o),
        .oScorePulse(pulse_o), .oScore(score_o)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            px[i] = pipe_x[i*17 +: 17];
            py[i] = pipe_y[i*17 +: 17];
        end
    end

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; state = 2'd0; rnd = 32'h0000_0100;
        step_clk(); step_clk();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (px[i] !== 17'(640 + i*275)) begin
                n_fail++; $display("FAIL reset_x%0d: got %0d expected %0d", i, px[i], 640 + i*275);
            end
            n_checks++;
            if (py[i] !== -17'sd1) begin
                n_fail++; $display("FAIL reset_y%0d: got %0d expected -1", i, py[i]);
            end
        end
        n_checks++;
        if (score_o !== 16'd0 || tick_o !== 1'b0 || pulse_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_out: score %0d tick %b pulse %b expected 0 0 0", score_o, tick_o, pulse_o);
        end
        $display("reset: X=%0d,%0d,%0d score=%0d", px[0], px[1], px[2], score_o);
    endtask

    task automatic test_fill();
        rst = 1'b0; state = 2'd1;
        for (int c = 0; c < 3; c++) begin
            step_clk();
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (py[i] !== ((i <= c) ? 17'sd56 : -17'sd1)) begin
                    n_fail++; $display("FAIL fill_c%0d_y%0d: got %0d expected %0d", c, i, py[i], (i <= c) ? 56 : -1);
                end
            end
            $display("fill cycle %0d: Y=%0d,%0d,%0d", c, py[0], py[1], py[2]);
        end
    endtask

    task automatic test_tick();
        n_checks++;
        if (tick_o !== 1'b1 || px[0] !== 17'sd640) begin
            n_fail++; $display("FAIL tick_first: tick %b X0 %0d expected 1 640", tick_o, px[0]);
        end
        step_clk();
        n_checks++;
        if (tick_o !== 1'b0 || px[0] !== 17'sd639 || px[2] !== 17'sd1189) begin
            n_fail++; $display("FAIL tick_dec: tick %b X0 %0d X2 %0d expected 0 639 1189", tick_o, px[0], px[2]);
        end
        for (int c = 0; c < 4; c++) step_clk();
        n_checks++;
        if (px[0] !== 17'sd638) begin
            n_fail++; $display("FAIL tick_second: got %0d expected 638", px[0]);
        end
        $display("tick: X0=%0d", px[0]);
    endtask

    task automatic test_freeze();
        state = 2'd2;
        for (int c = 0; c < 10; c++) begin
            step_clk();
            n_checks++;
            if (tick_o !== 1'b0 || px[0] !== 17'sd638) begin
                n_fail++; $display("FAIL freeze_c%0d: tick %b X0 %0d expected 0 638", c, tick_o, px[0]);
            end
        end
        $display("freeze: X0=%0d", px[0]);
        state = 2'd1;
    endtask

    task automatic test_score();
        int pulses = 0;
        int budget = 5000;
        while (px[0] !== 17'sd107 && budget > 0) begin
            step_clk();
            budget--;
            if (pulse_o === 1'b1) begin
                pulses++;
                n_checks++;
                if (px[0] !== 17'sd108 || tick_o !== 1'b1) begin
                    n_fail++; $display("FAIL score_pulse_pos: X0 %0d tick %b expected 108 1", px[0], tick_o);
                end
            end
        end
        n_checks++;
        if (budget == 0) begin
            n_fail++; $display("FAIL score_timeout: X0 %0d expected 107", px[0]);
        end
        n_checks++;
        if (pulses != 1 || score_o !== 16'd1) begin
            n_fail++; $display("FAIL score_count: pulses %0d score %0d expected 1 1", pulses, score_o);
        end
        $display("score: X0=%0d pulses=%0d score=%0d", px[0], pulses, score_o);
    endtask

    task automatic test_respawn();
        int budget = 5000;
        rnd = 32'h0000_0AB0;
        while (px[0] !== -17'sd53 && budget > 0) begin
            step_clk();
            budget--;
        end
        n_checks++;
        if (budget == 0 || px[2] !== 17'sd497 || py[0] !== 17'sd56) begin
            n_fail++; $display("FAIL respawn_pre: X0 %0d X2 %0d Y0 %0d expected -53 497 56", px[0], px[2], py[0]);
        end
        step_clk();
        n_checks++;
        if (px[0] !== 17'sd772) begin
            n_fail++; $display("FAIL respawn_x: got %0d expected 772", px[0]);
        end
        n_checks++;
        if (py[0] !== 17'sd211) begin
            n_fail++; $display("FAIL respawn_y: got %0d expected 211", py[0]);
        end
        n_checks++;
        if (px[0] - px[2] !== 17'sd275) begin
            n_fail++; $display("FAIL respawn_spacing: got %0d expected 275", px[0] - px[2]);
        end
        $display("respawn: X0=%0d Y0=%0d X2=%0d", px[0], py[0], px[2]);
    endtask

    task automatic test_idle_and_reset();
        state = 2'd0;
        step_clk();
        n_checks++;
        if (px[0] !== 17'sd640 || py[0] !== -17'sd1 || score_o !== 16'd0) begin
            n_fail++; $display("FAIL idle_defaults: X0 %0d Y0 %0d score %0d expected 640 -1 0", px[0], py[0], score_o);
        end
        state = 2'd1;
        for (int c = 0; c < 6; c++) step_clk();
        rst = 1'b1;
        step_clk();
        n_checks++;
        if (px[0] !== 17'sd640 || py[0] !== -17'sd1 || py[1] !== -17'sd1 || tick_o !== 1'b0) begin
            n_fail++; $display("FAIL midrun_reset: X0 %0d Y0 %0d Y1 %0d tick %b expected 640 -1 -1 0", px[0], py[0], py[1], tick_o);
        end
        $display("idle/reset: X0=%0d Y0=%0d", px[0], py[0]);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_tick();
        test_freeze();
        test_score();
        test_respawn();
        test_idle_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
